corefifo_wr_stage: RTL
======================

# corefifo_wr_stage

Write-side ingress stage for the COREFIFO controller, the counterpart to the FWFT read-side output stage. It accepts a ready/valid stream from upstream logic and generates `fifo_we`/`fifo_din` into the FIFO write port. A 2-entry skid buffer lets `s_ready` be a pure register output, with no combinational path from `fifo_full` to upstream, while sustaining one word per clock. It also provides a registered write acknowledge and a wrapping count of committed writes.

## Interface
Parameters:
- `WWIDTH`, 10: data width of the stream and the FIFO write port.
- `CNT_WIDTH`, 16: width of `wr_count`.

Ports:
- `wr_clk`, in, 1: write clock; all logic is on the rising edge.
- `sresetn_wclk`, in, 1: reset, synchronous and active-low.
- `s_valid`, in, 1: upstream word valid.
- `s_din`, in, WWIDTH: upstream data.
- `s_ready`, out, 1: stage can accept a word. Registered.
- `fifo_din`, out, WWIDTH: data to the FIFO write port. Registered.
- `fifo_we`, out, 1: active-high write enable to the FIFO controller.
- `fifo_full`, in, 1: registered full flag from the FIFO controller.
- `wr_ack`, out, 1: one-cycle pulse, one cycle after each committed write.
- `wr_count`, out, CNT_WIDTH: number of committed writes, wrapping.
- `occupancy`, out, 2: number of words held in the stage (0 to 2).

## Operation
- `push = s_valid & s_ready`.
- `pop = fifo_we = main_valid & !fifo_full`. This is the only combinational output.
- Storage:
  - `main` register drives `fifo_din`.
  - `skid` register holds the overflow word.
- States:
  - EMPTY: occupancy 0.
  - ONE: main valid.
  - TWO: main and skid valid.
- Transitions:
  - EMPTY, push: main <= s_din, go to ONE.
  - ONE, push & pop: main <= s_din, stay in ONE.
  - ONE, push & !pop: skid <= s_din, go to TWO.
  - ONE, !push & pop: go to EMPTY; main data is don't-care.
  - ONE, !push & !pop: hold.
  - TWO, pop: main <= skid, go to ONE. Push cannot occur in TWO because s_ready is 0.
  - TWO, !pop: hold.
- `s_ready <= (next_state != TWO)`.
- Ordering is strict FIFO. Words are never dropped or duplicated.
- `s_din` is sampled only on a push cycle. `s_din` with s_valid low is ignored.
- `wr_ack <= pop`.
- `wr_count <= wr_count + pop`, modulo 2^CNT_WIDTH. It wraps from all-ones to 0 without a flag.
- `occupancy` = 0 / 1 / 2 for EMPTY / ONE / TWO.
- `fifo_full` high with the stage in ONE or TWO: hold all data; s_ready settles to 0 once TWO is reached.
- `fifo_full` falling: pop occurs in the same cycle, because fifo_we is combinational on fifo_full.

## Timing
- Reset, when sresetn_wclk is low at an edge:
  - state = EMPTY, main_valid = 0.
  - s_ready = 0, fifo_din = 0, wr_ack = 0, wr_count = 0, occupancy = 0.
  - fifo_we = 0 (derived from main_valid).
- First edge with sresetn_wclk high: s_ready becomes 1.
- Reset mid-operation: buffered words are discarded and wr_count is cleared. Reset overrides any push or pop at that edge.
- Latency: a word pushed at edge k is on fifo_din with fifo_we high during cycle k+1, provided fifo_full is low.
- wr_ack follows at edge k+2.
- Throughput: with fifo_full held low and s_valid held high, 1 word per cycle; the state stays in ONE.
- Backpressure: fifo_full rising during a push cycle moves the stage to TWO at that edge, and s_ready is 0 from that edge onward.
- Recovery: when fifo_full falls, the first pop happens the same cycle. The state returns to ONE, and s_ready is 1 after that edge.
- Empty to full with one word accepted: fifo_we asserts, the controller asserts fifo_full the next cycle, and the stage holds further words.

## Test plan
- Reset then stream: release reset, drive s_valid=1 with data 1..8 and fifo_full=0.
  - fifo_we high for 8 consecutive cycles starting 2 edges after reset release.
  - fifo_din = 1..8 in order; wr_count = 8; occupancy never exceeds 1.
- Skid fill: stream 1..4, force fifo_full=1 on the cycle word 2 is pushed, hold it for 5 cycles, then release.
  - occupancy reaches 2 and s_ready stays 0 while full.
  - After release, fifo_din sequence is 1,2,3,4 with no loss or duplicate, and wr_ack count = 4.
- Bubbles: random s_valid at 50% and random fifo_full at 30%, 1000 words through a scoreboard.
  - Order is exact; wr_count = 1000 mod 2^16.
  - s_ready never high in TWO; fifo_we never high while fifo_full=1.
- Counter wrap with CNT_WIDTH=4: 17 writes -> wr_count = 1.
- Reset mid-operation: with occupancy=2, pull sresetn_wclk low for 1 cycle.
  - Next cycle: occupancy=0, fifo_we=0, wr_count=0, s_ready=0.
  - s_ready=1 one edge after release; the old words never appear.
- Same-cycle push/pop in ONE for 10 cycles: occupancy stays 1 and fifo_din updates every cycle.

Source files
------------

// File: rtl/corefifo_wr_stage.sv
// Write-side ingress stage for COREFIFO: a 2-entry skid buffer that registers s_ready
// and drives the FIFO write port, with a registered write acknowledge and a write count.
module corefifo_wr_stage #(
  parameter int WWIDTH    = 10,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 wr_clk,
  input  logic                 sresetn_wclk,
  input  logic                 s_valid,
  input  logic [WWIDTH-1:0]    s_din,
  output logic                 s_ready,
  output logic [WWIDTH-1:0]    fifo_din,
  output logic                 fifo_we,
  input  logic                 fifo_full,
  output logic                 wr_ack,
  output logic [CNT_WIDTH-1:0] wr_count,
  output logic [1:0]           occupancy
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WWIDTH-1:0]    main_q, main_d;
  logic [WWIDTH-1:0]    skid_q, skid_d;
  logic                 s_ready_q, s_ready_d;
  logic                 wr_ack_q, wr_ack_d;
  logic [CNT_WIDTH-1:0] wr_count_q, wr_count_d;
  logic                 main_valid;
  logic                 push;
  logic                 pop;

  always_comb begin
    main_valid = (state_q != ST_EMPTY);
    push       = s_valid & s_ready_q;
    pop        = main_valid & ~fifo_full;
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (push) begin
          main_d  = s_din;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (push && pop) begin
          main_d = s_din;
        end else if (push) begin
          skid_d  = s_din;
          state_d = ST_TWO;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        // s_ready is low here, so only the skid-to-main move can happen
        if (pop) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    s_ready_d  = (state_d != ST_TWO);
    wr_ack_d   = pop;
    wr_count_d = wr_count_q + {{(CNT_WIDTH-1){1'b0}}, pop};
  end

  always_ff @(posedge wr_clk) begin
    if (!sresetn_wclk) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      s_ready_q  <= 1'b0;
      wr_ack_q   <= 1'b0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      s_ready_q  <= s_ready_d;
      wr_ack_q   <= wr_ack_d;
      wr_count_q <= wr_count_d;
    end
  end

  // Skid data is only ever read while qualified by state, so it carries no reset
  always_ff @(posedge wr_clk) begin
    skid_q <= skid_d;
  end

  always_comb begin
    occupancy = 2'd0;
    case (state_q)
      ST_ONE:  occupancy = 2'd1;
      ST_TWO:  occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  assign fifo_we  = pop;
  assign fifo_din = main_q;
  assign s_ready  = s_ready_q;
  assign wr_ack   = wr_ack_q;
  assign wr_count = wr_count_q;

endmodule
